rca_seq_adder: RTL and testbench
================================

Name: rca_seq_adder

Overview:
- Multi-cycle N-bit adder/subtractor built around one shared 4-bit ripple-carry adder slice (s, c_out, x, y, c_in).
- Processes one 4-bit chunk per clock, LSB chunk first, and holds the carry in a register between chunks.
- Valid/ready handshake on both the input side and the result side.
- Used wherever a wide add/subtract is needed and one 4-bit RCA is cheaper than a WIDTH-bit adder.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
- NCHUNK, WIDTH/4, derived; number of RCA passes per operation (not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept an operand set.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  0: a+b+c_in; 1: a-b (computed as a + ~b + 1).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- c_out  output  1  final carry out; for sub, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, idx=0, carry_reg=0, a_reg=b_reg=0. Outputs after reset: sum=0, c_out=0, ovf=0, out_valid=0, in_ready=1.
- FSM states: IDLE, RUN, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE. Both are decoded from registered state only.
- IDLE:
  - on in_valid&&in_ready: a_reg<=a; b_reg<=sub ? ~b : b; carry_reg<=sub ? 1 : c_in; idx<=0; state<=RUN.
  - otherwise hold.
- RUN, each cycle:
  - The RCA is driven with x=a_reg[4*idx+:4], y=b_reg[4*idx+:4], c_in=carry_reg.
  - sum_reg[4*idx+:4]<=RCA s; carry_reg<=RCA c_out; idx<=idx+1.
  - When idx==NCHUNK-1: state<=DONE, c_out<=RCA c_out, ovf<=(a_reg[W-1] ~^ b_reg[W-1]) & (a_reg[W-1] ^ RCA s[3]). Here b_reg is the already-inverted B for sub.
- DONE:
  - sum, c_out and ovf are held stable.
  - On out_ready=1: state<=IDLE; sum, c_out and ovf keep their last values.
  - out_valid drops the cycle after the handshake.
- Latency: with the accept edge at T0, out_valid is high after edge T0+NCHUNK (4 cycles for WIDTH=16). Throughput is one operation per NCHUNK+2 cycles with out_ready held high.
- No bypass:
  - in_ready is 0 during the DONE handshake cycle; the next accept is possible at the following edge.
  - in_valid, a, b, sub and c_in are ignored outside IDLE.
  - out_ready is ignored outside DONE.
- Sum chunks not yet written in RUN keep their previous values. sum is only meaningful while out_valid=1.
- idx is sized to ceil(log2(NCHUNK)) bits, minimum 1 bit. It never wraps past NCHUNK-1.
- WIDTH=4 case: a single RUN cycle; the same RUN cycle goes straight to DONE.
- Reset mid-operation (RUN or DONE): aborts immediately. The partial result is discarded, all registers return to reset values, and in_ready=1 on the next cycle.

Test Plan:
1. WIDTH=16, a=0x1234, b=0x4321, c_in=0, sub=0 -> out_valid exactly 4 cycles after accept; sum=0x5555, c_out=0, ovf=0.
2. a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, ovf=0; carry propagates through all four chunks. Repeat with a=0xFFFF, b=0x0000, c_in=1 -> same result.
3. sub=1, a=0x0005, b=0x0007, c_in=1 (ignored) -> sum=0xFFFE, c_out=0, ovf=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, c_out=1, ovf=1.
4. a=0x7FFF, b=0x0001, add -> sum=0x8000, c_out=0, ovf=1. Also a=0x8000, b=0x8000 -> sum=0x0000, c_out=1, ovf=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid/a/b -> sum/c_out/ovf stable, in_ready=0, no new accept. Then raise out_ready -> out_valid=0 next cycle, in_ready=1, and the next operand is accepted with correct result.
6. Assert rst_n=0 for one cycle while idx=2 in RUN -> next cycle state=IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0. A following 0x0001+0x0001 returns 0x0002.

Source files
------------

// File: rtl/rca_seq_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor built on one shared 4-bit RCA slice.
// One nibble per clock, LSB first, with the carry held in a register.

module rca4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);

    logic [4:0] c;

    // Plain ripple chain, one full adder per bit
    always_comb begin
        c[0] = c_in;
        s    = '0;
        for (int i = 0; i < 4; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        c_out = c[4];
    end

endmodule

module rca_seq_adder #(
    parameter int WIDTH  = 16,
    parameter int NCHUNK = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);
    localparam logic [IW-1:0] ONE  = IW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             c_out_reg;
    logic             ovf_reg;

    logic [3:0]       rca_x;
    logic [3:0]       rca_y;
    logic [3:0]       rca_s;
    logic             rca_co;

    // Select the current nibble of each operand for the shared slice
    always_comb begin
        rca_x = a_reg[{idx, 2'b00} +: 4];
        rca_y = b_reg[{idx, 2'b00} +: 4];
    end

    rca4 u_rca (
        .x     (rca_x),
        .y     (rca_y),
        .c_in  (carry_reg),
        .s     (rca_s),
        .c_out (rca_co)
    );

    // Control FSM plus the operand, carry and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            c_out_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : c_in;
                        idx       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[{idx, 2'b00} +: 4] <= rca_s;
                    carry_reg <= rca_co;
                    if (idx == LAST) begin
                        state     <= DONE;
                        c_out_reg <= rca_co;
                        ovf_reg   <= (a_reg[WIDTH-1] ~^ b_reg[WIDTH-1])
                                   & (a_reg[WIDTH-1] ^ rca_s[3]);
                    end else begin
                        idx <= idx + ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags come straight from the registered state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        sum       = sum_reg;
        c_out     = c_out_reg;
        ovf       = ovf_reg;
    end

endmodule

// File: tb/tb_rca_seq_adder.sv
// Directed testbench for rca_seq_adder (WIDTH=16).
// Hand-computed vectors cover add, sub, carry, overflow, backpressure, reset.

module tb_rca_seq_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;

    int checks;
    int failures;

    rca_seq_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand set and return once it has been accepted
    task automatic start_op(input logic [15:0] va, input logic [15:0] vb,
                            input logic vc, input logic vs);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_before_accept", in_ready, 1);
        a        = va;
        b        = vb;
        c_in     = vc;
        sub      = vs;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, then compare the result
    task automatic wait_done(input string tag, input logic [15:0] es,
                             input logic ec, input logic eo);
        int n;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (out_valid) break;
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, c_out, ec);
        check({tag, "_ovf"}, ovf, eo);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, out_valid, 0);
        check({tag, "_ir_back"}, in_ready, 1);
    endtask

    task automatic run_op(input string tag,
                          input logic [15:0] va, input logic [15:0] vb,
                          input logic vc, input logic vs,
                          input logic [15:0] es, input logic ec,
                          input logic eo);
        start_op(va, vb, vc, vs);
        wait_done(tag, es, ec, eo);
        release_result(tag);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        sub       = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", c_out, 0);
        check("rst_ovf", ovf, 0);

        run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("carry_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("carry_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("add_povf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("add_novf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Backpressure: hold the result while the input side is busy
        start_op(16'h00F0, 16'h0F10, 1'b0, 1'b0);
        wait_done("bp", 16'h1000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = 16'h1111 * 16'(i + 1);
            b        = 16'h2222;
            sub      = i[0];
            tick();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_ready", in_ready, 0);
            check("bp_hold_sum", sum, 16'h1000);
            check("bp_hold_flags", {c_out, ovf}, 2'b00);
        end
        in_valid = 1'b0;
        sub      = 1'b0;
        release_result("bp");
        run_op("after_bp", 16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0);

        // Reset while idx=2 in RUN
        start_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_cout", c_out, 0);
        check("mid_rst_ovf", ovf, 0);
        run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
